// File: rtl/adc_serial_capture.sv
// ============================================================================
// adc_serial_capture : SPI-style serial front end for a 12-bit ADC
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module adc_serial_capture #(
  parameter int ADC_RES      = 12,
  parameter int FRAME_BITS   = 16,
  parameter int SCLK_DIV     = 4,
  parameter int QUIET_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               adc_sdata,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic [ADC_RES-1:0] sample,
  output logic               sample_valid,
  output logic               lead_err,
  output logic               busy
);

  localparam int CNT_MAX = (SCLK_DIV > QUIET_CYCLES) ? SCLK_DIV : QUIET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] C_DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [BIT_W-1:0] C_BITS_LAST  = BIT_W'(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4,
    QUIET    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic [ADC_RES-1:0]      sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    lead_q, lead_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      sample_q <= '0;
      valid_q  <= 1'b0;
      lead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      lead_q   <= lead_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    lead_d   = lead_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
        end
      end

      SETUP: begin
        if (cnt_q == C_DIV_LAST) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      SHIFT_LO: begin
        if (cnt_q == C_DIV_LAST) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
          shift_d = {shift_q[FRAME_BITS-2:0], adc_sdata};
          bit_d   = bit_q + 1'b1;
          cnt_d   = '0;
        end
      end

      SHIFT_HI: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == C_BITS_LAST) begin
            state_d  = DONE;
            cs_n_d   = 1'b1;
            sample_d = shift_q[ADC_RES-1:0];
            lead_d   = |shift_q[FRAME_BITS-1:ADC_RES];
            valid_d  = 1'b1;
            bit_d    = '0;
          end else begin
            state_d = SHIFT_LO;
            sclk_d  = 1'b0;
          end
        end
      end

      // DONE is the first cs_n-high cycle, so it counts toward the quiet gap.
      DONE, QUIET: begin
        if (cnt_q == C_QUIET_LAST) begin
          state_d = enable ? SETUP : IDLE;
          cs_n_d  = !enable;
          cnt_d   = '0;
        end else begin
          state_d = QUIET;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign lead_err     = lead_q;
  assign busy         = ~cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_capture.sv
// ============================================================================
// tb_adc_serial_capture : directed bench with a behavioural ADC model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_serial_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, enable, enable2, sdata1, sdata2;
  logic cs1, sclk1, v1, lead1, busy1;
  logic cs2, sclk2, v2, lead2, busy2;
  logic [11:0] smp1, smp2;

  adc_serial_capture dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .adc_sdata(sdata1),
    .adc_cs_n(cs1), .adc_sclk(sclk1), .sample(smp1), .sample_valid(v1),
    .lead_err(lead1), .busy(busy1)
  );

  adc_serial_capture #(.SCLK_DIV(2), .QUIET_CYCLES(1)) dut2 (
    .clk(clk), .rstn(rstn), .enable(enable2), .adc_sdata(sdata2),
    .adc_cs_n(cs2), .adc_sclk(sclk2), .sample(smp2), .sample_valid(v2),
    .lead_err(lead2), .busy(busy2)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ADC models: next word latched when cs_n falls, one bit per sclk fall
  logic [15:0] mwords1 [0:15];
  logic [15:0] cur1 = '0, cur2 = 16'h07A5;
  int fidx1 = 0, fall1 = 0, fall2 = 0;

  always @(negedge cs1) begin
    cur1 = mwords1[fidx1];
    fidx1++;
    fall1 = 0;
  end
  always @(negedge sclk1) if (!cs1 && fall1 < 16) begin
    sdata1 <= cur1[15-fall1];
    fall1++;
  end
  always @(negedge cs2) fall2 = 0;
  always @(negedge sclk2) if (!cs2 && fall2 < 16) begin
    sdata2 <= cur2[15-fall2];
    fall2++;
  end

  // Frame monitors sampled on the falling clk edge
  bit pcs1 = 1'b1, psclk1 = 1'b1, firstv1 = 1'b0, pcs2 = 1'b1;
  int low1 = 0, lastlow1 = 0, high1 = 0, lasthigh1 = 0, edges1 = 0, lastedges1 = 0;
  int vcnt1 = 0, vcyc1 = 0, pvcyc1 = 0;
  int low2 = 0, lastlow2 = 0, high2 = 0, lasthigh2 = 0, vcyc2 = 0, pvcyc2 = 0;

  always @(negedge clk) begin
    if (!cs1) begin
      if (pcs1) begin lasthigh1 = high1; high1 = 0; edges1 = 0; end
      low1++;
      if (!psclk1 && sclk1) edges1++;
    end else begin
      if (!pcs1) begin lastlow1 = low1; low1 = 0; lastedges1 = edges1; firstv1 = v1; end
      high1++;
    end
    if (v1) begin vcnt1++; pvcyc1 = vcyc1; vcyc1 = cyc; end
    pcs1 = cs1; psclk1 = sclk1;

    if (!cs2) begin
      if (pcs2) begin lasthigh2 = high2; high2 = 0; end
      low2++;
    end else begin
      if (!pcs2) begin lastlow2 = low2; low2 = 0; end
      high2++;
    end
    if (v2) begin pvcyc2 = vcyc2; vcyc2 = cyc; end
    pcs2 = cs2;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if ((which == 1 && v1) || (which == 2 && v2)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_edges(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (!cs1 && edges1 == n) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp_sample;
    logic        exp_lead;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int lowseen, vbefore;

    vecs[0] = '{16'h0ABC, 12'hABC, 1'b0};
    vecs[1] = '{16'h0FFF, 12'hFFF, 1'b0};
    vecs[2] = '{16'h0000, 12'h000, 1'b0};
    vecs[3] = '{16'h0800, 12'h800, 1'b0};
    vecs[4] = '{16'h8123, 12'h123, 1'b1};
    vecs[5] = '{16'h0456, 12'h456, 1'b0};
    for (int i = 0; i < 16; i++) mwords1[i] = 16'h0000;
    for (int i = 0; i < 6; i++) mwords1[i] = vecs[i].word;
    mwords1[6] = 16'h0321;
    mwords1[7] = 16'h0555;
    mwords1[8] = 16'h0A5A;

    rstn = 1'b0; enable = 1'b0; enable2 = 1'b0; sdata1 = 1'b0; sdata2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", cs1, 1'b1);
    check("rst_sclk", sclk1, 1'b1);
    check("rst_sample", smp1, 12'h000);
    check("rst_valid", v1, 1'b0);
    check("rst_lead", lead1, 1'b0);
    check("rst_busy", busy1, 1'b0);

    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_cs_n", cs1, 1'b1);

    enable = 1'b1;
    check("pre_edge_cs_n", cs1, 1'b1);
    @(negedge clk); #1;
    check("latency_cs_n", cs1, 1'b0);
    check("busy_in_frame", busy1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      wait_valid(1, ok);
      check($sformatf("v%0d_timeout", i), ok, 1'b1);
      check($sformatf("v%0d_sample", i), smp1, vecs[i].exp_sample);
      check($sformatf("v%0d_lead", i), lead1, vecs[i].exp_lead);
      check($sformatf("v%0d_low_len", i), lastlow1, 132);
      check($sformatf("v%0d_edges", i), lastedges1, 16);
      check($sformatf("v%0d_first_high", i), firstv1, 1'b1);
      if (i > 0) begin
        check($sformatf("v%0d_period", i), vcyc1 - pvcyc1, 140);
        check($sformatf("v%0d_quiet", i), lasthigh1, 8);
      end
      @(negedge clk); #1;
      check($sformatf("v%0d_pulse_end", i), v1, 1'b0);
      check($sformatf("v%0d_lead_hold", i), lead1, vecs[i].exp_lead);
    end

    // Drop enable mid-frame: frame 0x0321 must still complete
    wait_edges(5, ok);
    check("drop_edge_timeout", ok, 1'b1);
    enable = 1'b0;
    wait_valid(1, ok);
    check("drop_timeout", ok, 1'b1);
    check("drop_sample", smp1, 12'h321);
    check("drop_lead", lead1, 1'b0);

    // A sub-cycle enable glitch in IDLE must not start a frame
    @(negedge clk); #1;
    enable = 1'b1; #2; enable = 1'b0;
    lowseen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (!cs1) lowseen++;
    end
    check("idle_no_frame", lowseen, 0);
    check("idle_busy", busy1, 1'b0);

    // Reset mid-frame aborts frame 0x0555
    enable = 1'b1;
    wait_edges(10, ok);
    check("rst_edge_timeout", ok, 1'b1);
    vbefore = vcnt1;
    rstn = 1'b0;
    #1;
    check("abort_cs_n", cs1, 1'b1);
    check("abort_sclk", sclk1, 1'b1);
    check("abort_sample", smp1, 12'h000);
    check("abort_valid", v1, 1'b0);
    check("abort_busy", busy1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk); #1;
    check("restart_cs_n", cs1, 1'b0);
    wait_valid(1, ok);
    check("restart_timeout", ok, 1'b1);
    check("restart_vcount", vcnt1, vbefore + 1);
    check("restart_sample", smp1, 12'hA5A);
    check("restart_low_len", lastlow1, 132);
    enable = 1'b0;

    // Fast configuration: SCLK_DIV=2, QUIET_CYCLES=1
    enable2 = 1'b1;
    wait_valid(2, ok);
    check("fast1_timeout", ok, 1'b1);
    check("fast1_sample", smp2, 12'h7A5);
    check("fast1_low_len", lastlow2, 66);
    wait_valid(2, ok);
    check("fast2_timeout", ok, 1'b1);
    check("fast2_sample", smp2, 12'h7A5);
    check("fast2_lead", lead2, 1'b0);
    check("fast2_low_len", lastlow2, 66);
    check("fast2_period", vcyc2 - pvcyc2, 67);
    check("fast2_quiet", lasthigh2, 1);
    enable2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
